seq_lut_loader: RTL and testbench
=================================

Name: seq_lut_loader

Overview:
- Configuration controller for the sequencer FSM's 256x29 command LUT.
- Holds the sequencer in reset while loading. Accepts a valid/ready stream of command words from the host/register bus and writes them to the LUT through its auto-incrementing write port.
- Optionally reads the LUT back and checks a checksum, then releases the sequencer to run.
- Sits between the host config interface and the sequencer's reset/LUT pins.

Parameters:
- LUT_DEPTH, 256, number of LUT entries; maximum words per load.
- LUT_DW, 29, LUT word width (sof[28], eof[27], data_length[26:11], repeat[10:3], next_state[2:0]).
- CSUM_W, 32, checksum accumulator width.

Ports:
- clk  in  1  system clock.
- reset_ni  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; begins a load session (ignored unless IDLE/DONE/ERROR).
- abort_i  in  1  pulse; abandons the session, goes to ERROR with code 3.
- cfg_valid_i  in  1  host word valid.
- cfg_ready_o  out  1  loader accepts word.
- cfg_data_i  in  LUT_DW  command word.
- cfg_last_i  in  1  marks final word of the table.
- seq_hold_o  out  1  drives sequencer reset (high = held in RST).
- seq_addr_clr_o  out  1  one-cycle pulse; zeroes the sequencer LUT address.
- lut_wen_o  out  1  LUT write strobe; the LUT address auto-increments.
- lut_wdata_o  out  LUT_DW  LUT write data.
- lut_rden_o  out  1  LUT read strobe; the LUT address auto-increments.
- lut_rdata_i  in  LUT_DW  readback data, valid 1 cycle after lut_rden_o.
- busy_o  out  1  session in progress.
- done_o  out  1  one-cycle pulse on successful release.
- error_o  out  1  sticky until next start_i.
- err_code_o  out  2  0 none, 1 overflow, 2 checksum mismatch, 3 abort.
- words_loaded_o  out  9  words written in the current/last session.

Behaviour:
- Reset: state IDLE.
  - seq_hold_o=1, so the sequencer stays in RST until the first successful load.
  - All other outputs are 0; checksum and counters are 0.
- States: IDLE, CLR, WRITE, VCLR, VERIFY, VDRAIN, RELEASE, DONE, ERROR.
- IDLE/DONE/ERROR + start_i:
  - seq_hold_o<=1; clear counters, checksum, error_o and err_code_o.
  - Go to CLR.
- CLR: assert seq_addr_clr_o for 1 cycle, then go to WRITE.
- WRITE:
  - cfg_ready_o=1 while words_loaded_o<LUT_DEPTH.
  - On handshake, the next cycle has lut_wen_o=1 and lut_wdata_o=cfg_data_i. Registered, latency 1; back-to-back words give 1 write per cycle.
  - On handshake: wsum += zero-extended word (mod 2^CSUM_W); words_loaded_o++.
  - Handshake with cfg_last_i=1: go to VCLR (verify build) or RELEASE, after the final lut_wen_o has been issued.
  - Handshake when words_loaded_o==LUT_DEPTH and cfg_last_i=0: cannot occur, because ready is low. After LUT_DEPTH words without last, go to ERROR code 1.
- VCLR: pulse seq_addr_clr_o, then go to VERIFY.
- VERIFY:
  - Issue lut_rden_o each cycle until words_loaded_o strobes have been issued, then go to VDRAIN.
  - Each lut_rdata_i sample, taken one cycle after its strobe, is added to rsum.
- VDRAIN:
  - Wait 1 cycle for the last sample.
  - rsum==wsum: go to RELEASE.
  - Otherwise: go to ERROR code 2.
- RELEASE:
  - Pulse seq_addr_clr_o (address 0 for the first command).
  - Next cycle seq_hold_o<=0 and done_o=1 for 1 cycle, then go to DONE.
- DONE: seq_hold_o=0, busy_o=0; the sequencer runs.
- ERROR: seq_hold_o stays 1; error_o=1; busy_o=0.
- busy_o=1 in CLR..RELEASE.
- abort_i in any busy state goes to ERROR code 3 next cycle.
  - lut_wen_o and lut_rden_o are deasserted in that same cycle.
  - abort_i has priority over a simultaneous handshake; that word is not written.
- start_i while busy is ignored.
- start_i in DONE re-holds the sequencer mid-run; a new load is allowed.
- Zero-word session (cfg_last_i on the first word) still writes that one word. An empty table is impossible.
- Async reset mid-session aborts silently to IDLE with hold=1; no done_o or error.

Optional Feature:
- SEQ_LUT_VERIFY_EN defined: the VCLR/VERIFY/VDRAIN readback checksum path is present; lut_rden_o is active.
- Undefined:
  - WRITE goes directly to RELEASE.
  - lut_rden_o is tied 0 and lut_rdata_i is unused.
  - err_code 2 never occurs; the rsum/wsum logic is removed.

Decomposition:
- Package seq_lut_pkg:
  - state enum typedef.
  - err_code localparams.
  - LUT field offsets/widths.
  - LUT_DEPTH/LUT_DW defaults.
- One sub-module seq_lut_csum: accumulator with clear, add-enable and compare output; instanced for wsum and rsum.

Test Plan:
- Load 4 words (0x1000_0002, 0x0000_4803, 0x0000_2004, 0x0800_0007), last on word 4, with a model LUT:
  - expect 4 consecutive lut_wen_o with the same data.
  - expect done_o pulse; seq_hold_o falls 1 cycle after done.
  - expect words_loaded_o=4.
- Same load with the host dropping cfg_valid_i every other cycle -> writes are gapped, data/order preserved, result identical.
- SEQ_LUT_VERIFY_EN with the model LUT corrupting entry 2 (bit 11 flipped) -> ERROR, err_code_o=2, seq_hold_o stays 1, no done_o.
- 256 words without cfg_last_i:
  - cfg_ready_o drops after word 256.
  - ERROR code 1; words_loaded_o=256.
- abort_i on the same cycle as word 3's handshake -> only 2 writes, err_code_o=3; then start_i plus a valid 2-word load -> done_o, error_o cleared.
- reset_ni low during WRITE -> next cycle IDLE, seq_hold_o=1, lut_wen_o=0, counters 0.

Source files
------------

// File: rtl/seq_lut_pkg.sv
// seq_lut_pkg: shared types and constants for the sequencer LUT loader.
// State encoding, error codes, LUT word field layout and default sizes.
package seq_lut_pkg;

  localparam int LUT_DEPTH_D = 256;
  localparam int LUT_DW_D    = 29;
  localparam int CSUM_W_D    = 32;
  localparam int CNT_W       = 9;

  localparam int SOF_BIT = 28;
  localparam int EOF_BIT = 27;
  localparam int LEN_LSB = 11;
  localparam int LEN_W   = 16;
  localparam int REP_LSB = 3;
  localparam int REP_W   = 8;
  localparam int NXT_LSB = 0;
  localparam int NXT_W   = 3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OVF   = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_WRITE,
    S_VCLR,
    S_VERIFY,
    S_VDRAIN,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/seq_lut_loader_if.sv
// seq_lut_loader_if: host command-word stream (valid/ready with last).
// master = host side, slave = loader side.
interface seq_lut_loader_if
  import seq_lut_pkg::*;
#(
  parameter int DW = LUT_DW_D
) ();

  logic          valid;
  logic          ready;
  logic          last;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/seq_lut_csum.sv
// seq_lut_csum: modular sum accumulator with sync clear, add enable
// and an equality compare against another sum.
module seq_lut_csum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  input  logic [W-1:0] cmp,
  output logic [W-1:0] sum,
  output logic         match
);

  logic [W-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (add) begin
      acc_q <= acc_q + din;
    end
  end

  assign sum   = acc_q;
  assign match = (acc_q == cmp);

endmodule

// File: rtl/seq_lut_loader.sv
// seq_lut_loader: holds the sequencer in reset, streams host words into its LUT, releases it.
// Define SEQ_LUT_VERIFY_EN to add the readback checksum pass before release.
module seq_lut_loader
  import seq_lut_pkg::*;
#(
  parameter int LUT_DEPTH = LUT_DEPTH_D,
  parameter int LUT_DW    = LUT_DW_D,
  parameter int CSUM_W    = CSUM_W_D
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              abort_i,
  seq_lut_loader_if.slave   cfg,
  output logic              seq_hold_o,
  output logic              seq_addr_clr_o,
  output logic              lut_wen_o,
  output logic [LUT_DW-1:0] lut_wdata_o,
  output logic              lut_rden_o,
  input  logic [LUT_DW-1:0] lut_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        err_code_o,
  output logic [CNT_W-1:0]  words_loaded_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LUT_DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  words_q;
  logic              last_q, wen_q, hold_q;
  logic              done_q, err_q;
  logic [1:0]        code_q, code_d;
  logic [LUT_DW-1:0] wdata_q;
  logic              busy, accept, hs;

  assign busy = state_q inside {S_CLR, S_WRITE, S_VCLR,
                                S_VERIFY, S_VDRAIN, S_RELEASE};
  assign accept = start_i &&
                  (state_q inside {S_IDLE, S_DONE, S_ERROR});
  // abort wins over a word offered in the same cycle
  assign cfg.ready = (state_q == S_WRITE) && !last_q &&
                     (words_q < DEPTH_C) && !abort_i;
  assign hs = cfg.valid && cfg.ready;

`ifdef SEQ_LUT_VERIFY_EN
  logic [CNT_W-1:0]  rd_cnt_q;
  logic              rden, rden_q;
  logic              w_match, r_match, csum_ok;
  logic [CSUM_W-1:0] wsum, rsum;

  assign rden = (state_q == S_VERIFY) &&
                (rd_cnt_q < words_q) && !abort_i;
  assign csum_ok = w_match && r_match;
  assign lut_rden_o = rden;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_cnt_q <= '0;
      rden_q   <= 1'b0;
    end else begin
      rden_q <= rden;
      if (accept || state_q == S_VCLR) begin
        rd_cnt_q <= '0;
      end else if (rden) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end
  end

  seq_lut_csum #(.W(CSUM_W)) u_wsum (
    .clk   (clk),
    .rst_n (reset_ni),
    .clr   (accept),
    .add   (hs),
    .din   (CSUM_W'(cfg.data)),
    .cmp   (rsum),
    .sum   (wsum),
    .match (w_match)
  );

  // readback data arrives one cycle after its strobe
  seq_lut_csum #(.W(CSUM_W)) u_rsum (
    .clk   (clk),
    .rst_n (reset_ni),
    .clr   (accept),
    .add   (rden_q),
    .din   (CSUM_W'(lut_rdata_i)),
    .cmp   (wsum),
    .sum   (rsum),
    .match (r_match)
  );
`else
  logic              unused_rdata;
  logic [CSUM_W-1:0] unused_csum;
  assign unused_rdata = ^lut_rdata_i;
  assign unused_csum  = '0;
  assign lut_rden_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = ERR_NONE;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) state_d = S_CLR;
      end
      S_CLR: state_d = S_WRITE;
      S_WRITE: begin
        // leave only once the final write strobe is on the bus
        if (last_q) begin
`ifdef SEQ_LUT_VERIFY_EN
          state_d = S_VCLR;
`else
          state_d = S_RELEASE;
`endif
        end else if (words_q == DEPTH_C) begin
          state_d = S_ERROR;
          code_d  = ERR_OVF;
        end
      end
`ifdef SEQ_LUT_VERIFY_EN
      S_VCLR: state_d = S_VERIFY;
      S_VERIFY: begin
        if (rd_cnt_q == words_q) state_d = S_VDRAIN;
      end
      S_VDRAIN: begin
        if (csum_ok) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_ERROR;
          code_d  = ERR_CSUM;
        end
      end
`endif
      S_RELEASE: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (busy && abort_i) begin
      state_d = S_ERROR;
      code_d  = ERR_ABORT;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      words_q <= '0;
      last_q  <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      wen_q   <= hs;
      done_q  <= (state_q == S_RELEASE) && !abort_i;
      if (hs) wdata_q <= cfg.data;
      if (accept) begin
        words_q <= '0;
        last_q  <= 1'b0;
        hold_q  <= 1'b1;
        err_q   <= 1'b0;
        code_q  <= ERR_NONE;
      end else begin
        if (hs) begin
          words_q <= words_q + 1'b1;
          last_q  <= cfg.last;
        end
        // hold drops the cycle after the done pulse
        if (done_q) hold_q <= 1'b0;
        if (state_d == S_ERROR && state_q != S_ERROR) begin
          err_q  <= 1'b1;
          code_q <= code_d;
        end
      end
    end
  end

  assign seq_hold_o     = hold_q;
  assign seq_addr_clr_o = state_q inside {S_CLR, S_VCLR, S_RELEASE};
  assign lut_wen_o      = wen_q;
  assign lut_wdata_o    = wdata_q;
  assign busy_o         = busy;
  assign done_o         = done_q;
  assign error_o        = err_q;
  assign err_code_o     = code_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_seq_lut_loader.sv
// tb_seq_lut_loader: directed + randomized loads against a model LUT;
// expectations come from the sent word lists and the session rules.
module tb_seq_lut_loader;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        seq_hold_o, seq_addr_clr_o;
  logic        lut_wen_o, lut_rden_o;
  logic [28:0] lut_wdata_o;
  logic [28:0] lut_rdata_i = '0;
  logic        busy_o, done_o, error_o;
  logic [1:0]  err_code_o;
  logic [8:0]  words_loaded_o;

  seq_lut_loader_if cfg ();

  seq_lut_loader dut (
    .clk            (clk),
    .reset_ni       (reset_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .cfg            (cfg),
    .seq_hold_o     (seq_hold_o),
    .seq_addr_clr_o (seq_addr_clr_o),
    .lut_wen_o      (lut_wen_o),
    .lut_wdata_o    (lut_wdata_o),
    .lut_rden_o     (lut_rden_o),
    .lut_rdata_i    (lut_rdata_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .err_code_o     (err_code_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int ndone = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  int corrupt_idx = -1;
  logic hold_prev = 1'b1;
  logic [28:0] wlog[$];
  int          wcyc[$];
  logic [28:0] mem [256];
  logic [8:0]  lut_addr = '0;

  // model LUT with one shared auto-incrementing address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (seq_addr_clr_o) begin
      lut_addr <= '0;
    end else if (lut_wen_o) begin
      mem[lut_addr[7:0]] <= lut_wdata_o;
      lut_addr <= lut_addr + 1'b1;
    end else if (lut_rden_o) begin
      lut_rdata_i <= mem[lut_addr[7:0]] ^
        ((int'(lut_addr) == corrupt_idx) ? 29'h800 : 29'h0);
      lut_addr <= lut_addr + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (lut_wen_o) begin
      wlog.push_back(lut_wdata_o);
      wcyc.push_back(cyc);
    end
    if (done_o) begin
      ndone = ndone + 1;
      done_cyc = cyc;
    end
    if (hold_prev && !seq_hold_o) fall_cyc = cyc;
    hold_prev = seq_hold_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_session();
    wlog.delete();
    wcyc.delete();
    ndone = 0;
    done_cyc = 0;
    fall_cyc = 0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [28:0] d, input bit l, input bit gap);
    bit ok = 1'b0;
    cfg.valid = 1'b1;
    cfg.data = d;
    cfg.last = l;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cfg.ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cfg.valid = 1'b0;
    cfg.last = 1'b0;
    chk("hs_ready", 32'(ok), 1);
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_list(input logic [28:0] w[$], input int mode);
    foreach (w[i])
      send_word(w[i], i == w.size() - 1,
                mode == 1 ? 1'b1 :
                mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, 32'(ok), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_ok_load(input string tag, input logic [28:0] exp[$]);
    chk({tag, "_nwr"}, wlog.size(), exp.size());
    foreach (exp[i]) begin
      if (i < wlog.size())
        chk($sformatf("%s_wr%0d", tag, i), 32'(wlog[i]), 32'(exp[i]));
      chk($sformatf("%s_lut%0d", tag, i), 32'(mem[i]), 32'(exp[i]));
    end
    chk({tag, "_done"}, ndone, 1);
    chk({tag, "_holdlag"}, fall_cyc - done_cyc, 1);
    chk({tag, "_hold"}, 32'(seq_hold_o), 0);
    chk({tag, "_err"}, 32'(error_o), 0);
    chk({tag, "_code"}, 32'(err_code_o), 0);
    chk({tag, "_words"}, 32'(words_loaded_o), exp.size());
  endtask

  task automatic check_err(input string tag, input int nwr,
                           input int code, input int words);
    chk({tag, "_nwr"}, wlog.size(), nwr);
    chk({tag, "_err"}, 32'(error_o), 1);
    chk({tag, "_code"}, 32'(err_code_o), code);
    chk({tag, "_words"}, 32'(words_loaded_o), words);
    chk({tag, "_hold"}, 32'(seq_hold_o), 1);
    chk({tag, "_done"}, ndone, 0);
  endtask

  initial begin
    logic [28:0] tw[$];
    logic [28:0] q[$];
    int n;
    cfg.valid = 1'b0;
    cfg.last = 1'b0;
    cfg.data = '0;
    tw = '{29'h1000_0002, 29'h0000_4803, 29'h0000_2004, 29'h0800_0007};

    repeat (3) @(posedge clk);
    #1 reset_ni = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold", 32'(seq_hold_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(error_o), 0);
    chk("rst_code", 32'(err_code_o), 0);
    chk("rst_words", 32'(words_loaded_o), 0);
    chk("rst_wen", 32'(lut_wen_o), 0);
    chk("rst_rden", 32'(lut_rden_o), 0);
    chk("rst_ready", 32'(cfg.ready), 0);
    chk("rst_aclr", 32'(seq_addr_clr_o), 0);

    begin_session();
    send_list(tw, 0);
    wait_idle("t1");
    check_ok_load("t1", tw);
    chk("t1_b2b", wcyc[3] - wcyc[0], 3);

    begin_session();
    chk("rehold", 32'(seq_hold_o), 1);
    chk("rehold_busy", 32'(busy_o), 1);
    send_list(tw, 1);
    wait_idle("t2");
    check_ok_load("t2", tw);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_gap%0d", i), wcyc[i+1] - wcyc[i], 2);

    repeat (3) begin
      q.delete();
      n = $urandom_range(2, 24);
      repeat (n) q.push_back(29'($urandom));
      begin_session();
      send_list(q, 2);
      wait_idle("rnd");
      check_ok_load("rnd", q);
    end

`ifdef SEQ_LUT_VERIFY_EN
    corrupt_idx = 2;
    begin_session();
    send_list(tw, 0);
    wait_idle("vfy");
    check_err("vfy", 4, 2, 4);
    corrupt_idx = -1;
`endif

    q.delete();
    begin_session();
    for (int i = 0; i < 256; i++) begin
      q.push_back(29'($urandom));
      send_word(q[i], 1'b0, 1'b0);
    end
    cfg.valid = 1'b1;
    cfg.data = 29'h1;
    @(negedge clk);
    chk("ovf_ready", 32'(cfg.ready), 0);
    @(posedge clk); #1;
    cfg.valid = 1'b0;
    wait_idle("ovf");
    check_err("ovf", 256, 1, 256);
    chk("ovf_first", 32'(wlog[0]), 32'(q[0]));
    chk("ovf_last", 32'(wlog[255]), 32'(q[255]));

    q = '{29'($urandom), 29'($urandom), 29'($urandom)};
    begin_session();
    send_word(q[0], 1'b0, 1'b0);
    send_word(q[1], 1'b0, 1'b0);
    cfg.valid = 1'b1;
    cfg.data = q[2];
    abort_i = 1'b1;
    @(negedge clk);
    chk("abt_ready", 32'(cfg.ready), 0);
    @(posedge clk); #1;
    abort_i = 1'b0;
    cfg.valid = 1'b0;
    wait_idle("abt");
    check_err("abt", 2, 3, 2);
    chk("abt_w0", 32'(wlog[0]), 32'(q[0]));
    chk("abt_w1", 32'(wlog[1]), 32'(q[1]));

    q = '{29'($urandom), 29'($urandom)};
    begin_session();
    chk("restart_err", 32'(error_o), 0);
    chk("restart_code", 32'(err_code_o), 0);
    send_list(q, 0);
    wait_idle("restart");
    check_ok_load("restart", q);

    begin_session();
    send_word(29'h0ABC_DEF1, 1'b0, 1'b0);
    send_word(29'h0123_4567, 1'b0, 1'b0);
    reset_ni = 1'b0;
    #1;
    chk("arst_hold", 32'(seq_hold_o), 1);
    chk("arst_wen", 32'(lut_wen_o), 0);
    chk("arst_words", 32'(words_loaded_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_err", 32'(error_o), 0);
    chk("arst_ready", 32'(cfg.ready), 0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("arst_ndone", ndone, 0);
    chk("arst_idle_err", 32'(error_o), 0);

    q = '{29'($urandom)};
    begin_session();
    send_list(q, 0);
    wait_idle("one");
    check_ok_load("one", q);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
